circle_layer_mux: RTL

- Parametrised successor to the single-object circle and ball drawing stages in the VGA pixel pipeline.
- Overlays up to N_OBJ filled circles (players, puck, markers) onto rgb_in in one pipelined stage, each with its own position, radius, colour and enable.
- Object attributes are shadow-latched once per frame at vblank start to prevent tearing.
- Sits between draw_playground and the output registers, on the 65 MHz pixel clock.

---
 rtl/circle_layer_mux_if.sv | 47 ++++
 rtl/circle_layer_mux.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/circle_layer_mux_if.sv
// Pixel-stream and object-attribute bundle for circle_layer_mux.
// master drives the timing/pixel inputs and object attributes; slave is the compositor.
interface circle_layer_mux_if #(
    parameter int unsigned N_OBJ = 3,
    parameter int unsigned RAD_W = 8
);
    // upstream pixel stream
    logic [11:0]            hcount_in;
    logic [11:0]            vcount_in;
    logic                   hsync_in;
    logic                   vsync_in;
    logic                   hblnk_in;
    logic                   vblnk_in;
    logic [11:0]            rgb_in;

    // per-object attributes, object i in slice i
    logic [12*N_OBJ-1:0]    obj_xpos;
    logic [12*N_OBJ-1:0]    obj_ypos;
    logic [RAD_W*N_OBJ-1:0] obj_radius;
    logic [12*N_OBJ-1:0]    obj_color;
    logic [N_OBJ-1:0]       obj_en;

    // composited pixel stream
    logic [11:0]            hcount_out;
    logic [11:0]            vcount_out;
    logic                   hsync_out;
    logic                   vsync_out;
    logic                   hblnk_out;
    logic                   vblnk_out;
    logic [11:0]            rgb_out;
    logic [N_OBJ-1:0]       hit_mask;
    logic                   frame_tick;

    modport master (
        output hcount_in, vcount_in, hsync_in, vsync_in, hblnk_in, vblnk_in, rgb_in,
        output obj_xpos, obj_ypos, obj_radius, obj_color, obj_en,
        input  hcount_out, vcount_out, hsync_out, vsync_out, hblnk_out, vblnk_out,
        input  rgb_out, hit_mask, frame_tick
    );

    modport slave (
        input  hcount_in, vcount_in, hsync_in, vsync_in, hblnk_in, vblnk_in, rgb_in,
        input  obj_xpos, obj_ypos, obj_radius, obj_color, obj_en,
        output hcount_out, vcount_out, hsync_out, vsync_out, hblnk_out, vblnk_out,
        output rgb_out, hit_mask, frame_tick
    );
endinterface

// File: rtl/circle_layer_mux.sv
// Multi-object filled-circle overlay for the VGA pixel pipeline.
// Three-stage pipeline: |dx|,|dy| -> d2 <= r2 test -> priority colour select.
// Object attributes are sampled into shadow registers on each vblank rising edge.
module circle_layer_mux #(
    parameter int unsigned N_OBJ         = 3,
    parameter int unsigned PRIORITY_HIGH = 0,
    parameter int unsigned RAD_W         = 8
) (
    input logic               clk_in,
    input logic               rst,
    circle_layer_mux_if.slave bus
);

    localparam int unsigned D2_W  = 25;
    localparam int unsigned R2_W  = 2 * RAD_W;
    localparam int unsigned CMP_W = (D2_W > R2_W) ? D2_W : R2_W;

    typedef struct packed {
        logic [11:0] hcount;
        logic [11:0] vcount;
        logic        hsync;
        logic        vsync;
        logic        hblnk;
        logic        vblnk;
        logic [11:0] rgb;
    } pix_t;

    // Magnitude of a 13-bit signed difference; always fits in 12 bits.
    function automatic logic [11:0] abs_diff(input logic [11:0] a, input logic [11:0] b);
        logic [12:0] diff;
        diff = {1'b0, a} - {1'b0, b};
        return diff[12] ? 12'(-diff) : diff[11:0];
    endfunction

    // ------------------------------------------------------------------
    // Shadow attribute registers
    // ------------------------------------------------------------------
    logic             vblnk_prev_q;
    logic             load;
    logic             frame_tick_q;
    logic [11:0]      sh_x_q   [N_OBJ];
    logic [11:0]      sh_y_q   [N_OBJ];
    logic [RAD_W-1:0] sh_r_q   [N_OBJ];
    logic [11:0]      sh_col_q [N_OBJ];
    logic [N_OBJ-1:0] sh_en_q;

    assign load = bus.vblnk_in & ~vblnk_prev_q;

    // Edge-detect vblank and latch all object attributes on its rising edge.
    // The previous-vblank flag resets high so a vblank held across reset release
    // is not mistaken for a fresh edge.
    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            vblnk_prev_q <= 1'b1;
            frame_tick_q <= 1'b0;
            sh_en_q      <= '0;
            for (int i = 0; i < int'(N_OBJ); i++) begin
                sh_x_q[i]   <= '0;
                sh_y_q[i]   <= '0;
                sh_r_q[i]   <= '0;
                sh_col_q[i] <= '0;
            end
        end else begin
            vblnk_prev_q <= bus.vblnk_in;
            frame_tick_q <= load;
            if (load) begin
                sh_en_q <= bus.obj_en;
                for (int i = 0; i < int'(N_OBJ); i++) begin
                    sh_x_q[i]   <= bus.obj_xpos[12*i +: 12];
                    sh_y_q[i]   <= bus.obj_ypos[12*i +: 12];
                    sh_r_q[i]   <= bus.obj_radius[RAD_W*i +: RAD_W];
                    sh_col_q[i] <= bus.obj_color[12*i +: 12];
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Stage 1: per-object absolute distances
    // ------------------------------------------------------------------
    pix_t        in_pix;
    pix_t        s1_q;
    logic [11:0] dx_d [N_OBJ];
    logic [11:0] dy_d [N_OBJ];
    logic [11:0] dx_q [N_OBJ];
    logic [11:0] dy_q [N_OBJ];

    // Bundle the incoming timing and colour and compute per-object |dx|, |dy|.
    always_comb begin
        in_pix.hcount = bus.hcount_in;
        in_pix.vcount = bus.vcount_in;
        in_pix.hsync  = bus.hsync_in;
        in_pix.vsync  = bus.vsync_in;
        in_pix.hblnk  = bus.hblnk_in;
        in_pix.vblnk  = bus.vblnk_in;
        in_pix.rgb    = bus.rgb_in;
        for (int i = 0; i < int'(N_OBJ); i++) begin
            dx_d[i] = abs_diff(bus.hcount_in, sh_x_q[i]);
            dy_d[i] = abs_diff(bus.vcount_in, sh_y_q[i]);
        end
    end

    // Stage 1 registers.
    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            s1_q <= '0;
            for (int i = 0; i < int'(N_OBJ); i++) begin
                dx_q[i] <= '0;
                dy_q[i] <= '0;
            end
        end else begin
            s1_q <= in_pix;
            for (int i = 0; i < int'(N_OBJ); i++) begin
                dx_q[i] <= dx_d[i];
                dy_q[i] <= dy_d[i];
            end
        end
    end

    // ------------------------------------------------------------------
    // Stage 2: squared distance against squared radius
    // ------------------------------------------------------------------
    pix_t             s2_q;
    logic [D2_W-1:0]  d2_d [N_OBJ];
    logic [CMP_W-1:0] r2_d [N_OBJ];
    logic [N_OBJ-1:0] inside_d;
    logic [N_OBJ-1:0] inside_q;

    // Full-width d2 (max 2*4095^2 < 2^25) and inclusive-edge inside test.
    always_comb begin
        inside_d = '0;
        for (int i = 0; i < int'(N_OBJ); i++) begin
            d2_d[i]     = D2_W'(dx_q[i]) * D2_W'(dx_q[i]) + D2_W'(dy_q[i]) * D2_W'(dy_q[i]);
            r2_d[i]     = CMP_W'(sh_r_q[i]) * CMP_W'(sh_r_q[i]);
            inside_d[i] = sh_en_q[i] & (CMP_W'(d2_d[i]) <= r2_d[i]);
        end
    end

    // Stage 2 registers.
    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            s2_q     <= '0;
            inside_q <= '0;
        end else begin
            s2_q     <= s1_q;
            inside_q <= inside_d;
        end
    end

    // ------------------------------------------------------------------
    // Stage 3: priority colour select and blanking
    // ------------------------------------------------------------------
    pix_t             out_d;
    pix_t             s3_q;
    logic [N_OBJ-1:0] hit_d;
    logic [N_OBJ-1:0] hit_q;
    int               idx;

    // Walk objects from lowest to highest priority so the last hit wins.
    always_comb begin
        out_d = s2_q;
        hit_d = inside_q;
        idx   = 0;
        for (int k = 0; k < int'(N_OBJ); k++) begin
            idx = (PRIORITY_HIGH != 0) ? k : int'(N_OBJ) - 1 - k;
            if (inside_q[idx]) begin
                out_d.rgb = sh_col_q[idx];
            end
        end
        if (s2_q.hblnk || s2_q.vblnk) begin
            out_d.rgb = '0;
            hit_d     = '0;
        end
    end

    // Output registers.
    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            s3_q  <= '0;
            hit_q <= '0;
        end else begin
            s3_q  <= out_d;
            hit_q <= hit_d;
        end
    end

    assign bus.hcount_out = s3_q.hcount;
    assign bus.vcount_out = s3_q.vcount;
    assign bus.hsync_out  = s3_q.hsync;
    assign bus.vsync_out  = s3_q.vsync;
    assign bus.hblnk_out  = s3_q.hblnk;
    assign bus.vblnk_out  = s3_q.vblnk;
    assign bus.rgb_out    = s3_q.rgb;
    assign bus.hit_mask   = hit_q;
    assign bus.frame_tick = frame_tick_q;

endmodule
